// File: rtl/branch_resolver_pkg.sv
// Shared widths and prediction-record layout for the branch resolver.
// Record layout (LSB first): pc | pred | pred_next.
package branch_resolver_pkg;

    localparam int MemAddrBus  = 32;
    localparam int BTBAllBytes = 16;

    // Record field offsets as a function of the address width.
    function automatic int rec_w(input int aw);
        return 2 * aw + 1;
    endfunction

    function automatic int rec_pc_lsb(input int aw);
        return (aw > 0) ? 0 : 0;
    endfunction

    function automatic int rec_pred_bit(input int aw);
        return aw;
    endfunction

    function automatic int rec_next_lsb(input int aw);
        return aw + 1;
    endfunction

    localparam int PredRecBus = rec_w(MemAddrBus);

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// In-order FIFO of fetch prediction records.
// Synchronous write, combinational read of the head entry; clear wins over push/pop.
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PredRecBus
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    assign rdata = mem[head];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Record storage; only written on an accepted push, no reset needed.
    always_ff @(posedge clock) begin
        if (push && !clear)
            mem[tail] <= wdata;
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues IF predictions, checks them against EX outcomes,
// trains the BTB and raises a flush with the correct redirect pc.
// Optional BRANCH_STATS_EN adds saturating branch / mispredict counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = MemAddrBus,
    parameter int BTB_ALL_W = BTBAllBytes
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [ADDR_W-1:0]    if_pc,
    input  logic                 if_prediction,
    input  logic [ADDR_W-1:0]    if_pred_next,
    output logic                 if_stall,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic                 ex_taken,
    input  logic [ADDR_W-1:0]    ex_target,
    output logic                 btb_update,
    output logic                 btb_committed,
    output logic [BTB_ALL_W-1:0] btb_current,
    output logic [ADDR_W-1:0]    btb_target,
    output logic                 flush,
    output logic [ADDR_W-1:0]    redirect_pc,
`ifdef BRANCH_STATS_EN
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts,
`endif
    output logic                 empty
);

    localparam int REC_W    = rec_w(ADDR_W);
    localparam int PC_LSB   = rec_pc_lsb(ADDR_W);
    localparam int PRED_BIT = rec_pred_bit(ADDR_W);
    localparam int NEXT_LSB = rec_next_lsb(ADDR_W);

    logic [REC_W-1:0]  wr_rec, rd_rec;
    logic              full, fifo_empty;
    logic              push_ok, pop_ok;
    logic [ADDR_W-1:0] rd_pc, rd_next, actual_next;
    logic              rd_pred, mispredict;

    assign wr_rec = {if_pred_next, if_prediction, if_pc};

    // Nothing moves during the flush cycle; the queue is cleared at its end.
    assign push_ok = if_valid && !full && !flush;
    assign pop_ok  = ex_valid && !fifo_empty && !flush;

    pred_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop_ok),
        .clear (flush),
        .wdata (wr_rec),
        .rdata (rd_rec),
        .full  (full),
        .empty (fifo_empty)
    );

    assign if_stall = full;
    assign empty    = fifo_empty;

    assign rd_pc   = rd_rec[PC_LSB +: ADDR_W];
    assign rd_pred = rd_rec[PRED_BIT];
    assign rd_next = rd_rec[NEXT_LSB +: ADDR_W];

    assign actual_next = (ex_is_branch && ex_taken) ? ex_target : (rd_pc + ADDR_W'(4));
    assign mispredict  = (actual_next != rd_next);

    // Resolution results, registered and held for a single cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btb_update    <= 1'b0;
            btb_committed <= 1'b0;
            btb_current   <= '0;
            btb_target    <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
        end else begin
            btb_update    <= pop_ok && (ex_is_branch || rd_pred);
            btb_committed <= pop_ok && ex_is_branch && ex_taken;
            btb_current   <= pop_ok ? rd_pc[BTB_ALL_W+1:2] : '0;
            btb_target    <= pop_ok ? ex_target : '0;
            flush         <= pop_ok && mispredict;
            redirect_pc   <= pop_ok ? actual_next : '0;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating event counters for resolved branches and mispredicts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (pop_ok && ex_is_branch && (stat_branches != 32'hFFFF_FFFF))
                stat_branches <= stat_branches + 32'd1;
            if (pop_ok && mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed vectors, immediate assertions.
module tb_branch_resolver;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_prediction;
    logic [31:0] if_pred_next;
    logic        if_stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        btb_update;
    logic        btb_committed;
    logic [15:0] btb_current;
    logic [31:0] btb_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        empty;

    int vectors = 0;
    int fails   = 0;

    always #5 clock = ~clock;

    branch_resolver dut (
        .clock         (clock),
        .reset         (reset),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_prediction (if_prediction),
        .if_pred_next  (if_pred_next),
        .if_stall      (if_stall),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .btb_update    (btb_update),
        .btb_committed (btb_committed),
        .btb_current   (btb_current),
        .btb_target    (btb_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .empty         (empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; if_pc = '0; if_prediction = 1'b0; if_pred_next = '0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pred, input logic [31:0] nxt);
        if_valid = 1'b1; if_pc = pc; if_prediction = pred; if_pred_next = nxt;
    endtask

    task automatic set_pop(input logic br, input logic tk, input logic [31:0] tgt);
        ex_valid = 1'b1; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst_flush", flush, 0);
        chk("rst_upd", btb_update, 0);
        chk("rst_cur", btb_current, 0);
        chk("rst_redir", redirect_pc, 0);
        chk("rst_empty", empty, 1);
        chk("rst_stall", if_stall, 0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // Correct not-taken
        set_push(32'h100, 1'b0, 32'h104);
        cyc();
        chk("nt_notempty", empty, 0);
        idle(); set_pop(1'b1, 1'b0, 32'h500);
        cyc();
        chk("nt_upd", btb_update, 1);
        chk("nt_comm", btb_committed, 0);
        chk("nt_cur", btb_current, 16'h40);
        chk("nt_tgt", btb_target, 32'h500);
        chk("nt_flush", flush, 0);
        chk("nt_empty", empty, 1);
        idle();
        cyc();
        chk("nt_upd_pulse", btb_update, 0);

        // Taken mispredict
        set_push(32'h200, 1'b0, 32'h204);
        cyc();
        idle(); set_pop(1'b1, 1'b1, 32'h180);
        cyc();
        chk("tk_flush", flush, 1);
        chk("tk_redir", redirect_pc, 32'h180);
        chk("tk_comm", btb_committed, 1);
        chk("tk_tgt", btb_target, 32'h180);
        chk("tk_cur", btb_current, 16'h80);
        idle();
        cyc();
        chk("tk_flush_pulse", flush, 0);
        chk("tk_empty", empty, 1);

        // Full queue: four records, then refused push with same-cycle pop
        for (int i = 0; i < 4; i++) begin
            set_push(32'h1000 + 32'(16 * i), 1'b0, 32'h1004 + 32'(16 * i));
            cyc();
        end
        chk("full_stall", if_stall, 1);
        set_push(32'h1040, 1'b0, 32'h1044);
        set_pop(1'b1, 1'b0, 32'h0);
        cyc();
        chk("full_stall_drop", if_stall, 0);
        chk("full_upd", btb_update, 1);
        chk("full_cur", btb_current, 16'h400);
        chk("full_flush", flush, 0);
        idle();
        for (int i = 1; i < 4; i++) begin
            set_pop(1'b0, 1'b0, 32'h0);
            cyc();
            chk("full_drain_cur", btb_current, 16'h400 + 16'(4 * i));
            chk("full_drain_flush", flush, 0);
        end
        chk("full_three_left", empty, 1);
        // Pop with empty queue is ignored
        set_pop(1'b1, 1'b1, 32'h777);
        cyc();
        chk("emp_pop_upd", btb_update, 0);
        chk("emp_pop_flush", flush, 0);
        idle();

        // Alias: non-branch predicted taken
        set_push(32'h300, 1'b1, 32'h400);
        cyc();
        idle(); set_pop(1'b0, 1'b0, 32'h0);
        cyc();
        chk("al_flush", flush, 1);
        chk("al_redir", redirect_pc, 32'h304);
        chk("al_upd", btb_update, 1);
        chk("al_comm", btb_committed, 0);
        idle();
        cyc();

        // Wrap and flush ordering: records k at pc 0x2000+0x40*k
        for (int k = 1; k <= 3; k++) begin
            set_push(32'h2000 + 32'(64 * k), 1'b0, 32'h2004 + 32'(64 * k));
            cyc();
        end
        for (int k = 1; k <= 6; k++) begin
            set_push(32'h2000 + 32'(64 * (k + 3)), 1'b0, 32'h2004 + 32'(64 * (k + 3)));
            set_pop(1'b1, 1'b0, 32'h0);
            cyc();
            chk("wr_cur", btb_current, 16'h800 + 16'(16 * k));
            chk("wr_upd", btb_update, 1);
            chk("wr_flush", flush, 0);
        end
        // Record 7 resolves taken while 8-9 queued; push 10 same cycle
        set_push(32'h2000 + 32'(64 * 10), 1'b0, 32'h2004 + 32'(64 * 10));
        set_pop(1'b1, 1'b1, 32'h9000);
        cyc();
        chk("wr7_flush", flush, 1);
        chk("wr7_redir", redirect_pc, 32'h9000);
        chk("wr7_cur", btb_current, 16'h870);
        // Pop of 8 and a push during the flush cycle are ignored
        set_push(32'h5000, 1'b0, 32'h5004);
        set_pop(1'b1, 1'b0, 32'h0);
        cyc();
        chk("wr_postflush_upd", btb_update, 0);
        chk("wr_postflush_flush", flush, 0);
        chk("wr_cleared", empty, 1);
        idle(); set_pop(1'b1, 1'b0, 32'h0);
        cyc();
        chk("wr_pop9_ignored", btb_update, 0);
        idle();
        cyc();

        // Async reset while flush is high
        set_push(32'h3000, 1'b1, 32'h5000);
        cyc();
        set_push(32'h3010, 1'b0, 32'h3014);
        set_pop(1'b0, 1'b0, 32'h0);
        cyc();
        chk("ar_flush_pre", flush, 1);
        chk("ar_notempty", empty, 0);
        idle();
        #2;
        reset = 1'b0;
        #1;
        chk("ar_flush", flush, 0);
        chk("ar_upd", btb_update, 0);
        chk("ar_empty", empty, 1);
        chk("ar_redir", redirect_pc, 0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("ar_after", btb_update, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
